// File: rtl/sync_fifo_checker_pkg.sv
// Shared constants and types for the synchronous FIFO protocol checker.
// Bit positions in ErrVector double as the codes reported in FirstErrCode.
package sync_fifo_checker_pkg;

    localparam int unsigned ErrNum = 8;

    localparam int unsigned BitFull        = 0;
    localparam int unsigned BitEmpty       = 1;
    localparam int unsigned BitOverflow    = 2;
    localparam int unsigned BitUnderflow   = 3;
    localparam int unsigned BitData        = 4;
    localparam int unsigned BitCount       = 5;
    localparam int unsigned BitAlmostFull  = 6;
    localparam int unsigned BitAlmostEmpty = 7;

    typedef enum logic [2:0] {
        ErrFull        = 3'd0,
        ErrEmpty       = 3'd1,
        ErrOverflow    = 3'd2,
        ErrUnderflow   = 3'd3,
        ErrData        = 3'd4,
        ErrCount       = 3'd5,
        ErrAlmostFull  = 3'd6,
        ErrAlmostEmpty = 3'd7
    } err_code_t;

    // Lowest set bit wins when several checks fail in the same cycle.
    function automatic err_code_t lowest_err(input logic [ErrNum-1:0] v);
        err_code_t code;
        logic      found;
        code  = ErrFull;
        found = 1'b0;
        for (int unsigned i = 0; i < ErrNum; i++) begin
            if (v[i] && !found) begin
                code  = err_code_t'(i);
                found = 1'b1;
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/sync_fifo_checker_model.sv
// Reference FIFO: shadow storage, wrapping pointers and occupancy.
// Acceptance is decided from pre-edge occupancy only.
module sync_fifo_checker_model
    import sync_fifo_checker_pkg::*;
#(
    parameter int unsigned DataSize = 8,
    parameter int unsigned Depth    = 8,
    parameter int unsigned CW       = 4
)(
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Push,
    input  logic                Pop,
    input  logic [DataSize-1:0] DataIn,
    output logic                PushAcc,
    output logic                PopAcc,
    output logic [DataSize-1:0] HeadData,
    output logic [CW-1:0]       ModelCount
);

    localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PW-1:0] LastPtr = PW'(Depth - 1);
    localparam logic [CW-1:0] FullCount = CW'(Depth);

    logic [DataSize-1:0] mem [Depth];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    // A push at full is refused even when a pop frees a slot in the same cycle.
    always_comb begin
        PushAcc  = Push && (ModelCount != FullCount);
        PopAcc   = Pop  && (ModelCount != '0);
        HeadData = mem[rd_ptr];
    end

    always_ff @(posedge Clk) begin
        if (PushAcc && !Reset) begin
            mem[wr_ptr] <= DataIn;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ModelCount <= '0;
        end else begin
            if (PushAcc) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (PopAcc) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            unique case ({PushAcc, PopAcc})
                2'b10:   ModelCount <= ModelCount + 1'b1;
                2'b01:   ModelCount <= ModelCount - 1'b1;
                default: ModelCount <= ModelCount;
            endcase
        end
    end

endmodule

// File: rtl/sync_fifo_checker.sv
// Protocol checker for a synchronous FIFO: compares observed DUT status and
// data against a shadow model and keeps a sticky, clearable error record.
module sync_fifo_checker
    import sync_fifo_checker_pkg::*;
#(
    parameter int unsigned DataSize         = 8,
    parameter int unsigned Depth            = 8,
    parameter int unsigned AlmostFullLevel  = Depth - 1,
    parameter int unsigned AlmostEmptyLevel = 1,
    parameter bit          FwftMode         = 1'b0,
    localparam int unsigned CW              = $clog2(Depth + 1)
)(
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Push,
    input  logic                Pop,
    input  logic [DataSize-1:0] DataIn,
    input  logic [DataSize-1:0] DataOut,
    input  logic                Full,
    input  logic                Empty,
    input  logic                AlmostFull,
    input  logic                AlmostEmpty,
    input  logic [CW-1:0]       Count,
    input  logic                ErrClear,
    output logic [ErrNum-1:0]   ErrVector,
    output logic [15:0]         ErrCount,
    output logic                FirstErrValid,
    output err_code_t           FirstErrCode,
    output logic [CW-1:0]       ModelCount
);

    logic                push_acc;
    logic                pop_acc;
    logic [DataSize-1:0] head_data;
    logic [31:0]         occ;
    logic                exp_valid;
    logic [DataSize-1:0] exp_data;
    logic                data_err;
    logic [ErrNum-1:0]   err_now;

    sync_fifo_checker_model #(
        .DataSize (DataSize),
        .Depth    (Depth),
        .CW       (CW)
    ) u_model (
        .Clk        (Clk),
        .Reset      (Reset),
        .Push       (Push),
        .Pop        (Pop),
        .DataIn     (DataIn),
        .PushAcc    (push_acc),
        .PopAcc     (pop_acc),
        .HeadData   (head_data),
        .ModelCount (ModelCount)
    );

    // Registered-read mode: remember the popped word for next cycle's compare.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            exp_valid <= 1'b0;
            exp_data  <= '0;
        end else begin
            exp_valid <= pop_acc;
            if (pop_acc) begin
                exp_data <= head_data;
            end
        end
    end

    always_comb begin
        occ = 32'(ModelCount);
        if (FwftMode) begin
            data_err = (occ != 0) && (DataOut != head_data);
        end else begin
            data_err = exp_valid && (DataOut != exp_data);
        end
    end

    always_comb begin
        err_now                 = '0;
        err_now[BitFull]        = Full  != (occ == Depth);
        err_now[BitEmpty]       = Empty != (occ == 0);
        err_now[BitOverflow]    = Push  && (occ == Depth);
        err_now[BitUnderflow]   = Pop   && (occ == 0);
        err_now[BitData]        = data_err;
        err_now[BitCount]       = Count != ModelCount;
        err_now[BitAlmostFull]  = AlmostFull  != (occ >= AlmostFullLevel);
        err_now[BitAlmostEmpty] = AlmostEmpty != (occ <= AlmostEmptyLevel);
    end

    // Reset and clear both discard whatever the checks flag in that cycle.
    always_ff @(posedge Clk) begin
        if (Reset || ErrClear) begin
            ErrVector     <= '0;
            ErrCount      <= '0;
            FirstErrValid <= 1'b0;
            FirstErrCode  <= ErrFull;
        end else begin
            ErrVector <= ErrVector | err_now;
            if (|err_now) begin
                if (ErrCount != '1) begin
                    ErrCount <= ErrCount + 16'd1;
                end
                if (!FirstErrValid) begin
                    FirstErrValid <= 1'b1;
                    FirstErrCode  <= lowest_err(err_now);
                end
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_checker.sv
// Self-checking bench for sync_fifo_checker (Depth=4, 8-bit, levels 3/1, registered read).
// The bench plays the observed FIFO and predicts the checker's registered outputs.
module tb_sync_fifo_checker;

    typedef struct {
        logic [7:0]  vec;
        logic [15:0] cnt;
        logic        fv;
        logic [2:0]  fc;
        logic [2:0]  mc;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Push = 1'b0;
    logic        Pop = 1'b0;
    logic        ErrClear = 1'b0;
    logic        Full = 1'b0;
    logic        Empty = 1'b1;
    logic        AlmostFull = 1'b0;
    logic        AlmostEmpty = 1'b1;
    logic [7:0]  DataIn = '0;
    logic [7:0]  DataOut = '0;
    logic [2:0]  Count = '0;
    logic [7:0]  ErrVector;
    logic [15:0] ErrCount;
    logic        FirstErrValid;
    logic [2:0]  FirstErrCode;
    logic [2:0]  ModelCount;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [7:0]  mq [$];
    exp_t        sbq [$];
    logic        pend_v = 1'b0;
    logic [7:0]  pend_d = '0;
    logic [7:0]  m_vec = '0;
    logic [15:0] m_cnt = '0;
    logic        m_fv = 1'b0;
    logic [2:0]  m_fc = '0;

    always #5 Clk = ~Clk;

    sync_fifo_checker #(
        .DataSize         (8),
        .Depth            (4),
        .AlmostFullLevel  (3),
        .AlmostEmptyLevel (1),
        .FwftMode         (1'b0)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Push          (Push),
        .Pop           (Pop),
        .DataIn        (DataIn),
        .DataOut       (DataOut),
        .Full          (Full),
        .Empty         (Empty),
        .AlmostFull    (AlmostFull),
        .AlmostEmpty   (AlmostEmpty),
        .Count         (Count),
        .ErrClear      (ErrClear),
        .ErrVector     (ErrVector),
        .ErrCount      (ErrCount),
        .FirstErrValid (FirstErrValid),
        .FirstErrCode  (FirstErrCode),
        .ModelCount    (ModelCount)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a well-behaved FIFO for the current bench occupancy; callers may then inject faults.
    task automatic setup(input logic push, input logic pop, input logic [7:0] din);
        int sz;
        sz          = mq.size();
        Reset       = 1'b0;
        ErrClear    = 1'b0;
        Push        = push;
        Pop         = pop;
        DataIn      = din;
        Full        = (sz == 4);
        Empty       = (sz == 0);
        AlmostFull  = (sz >= 3);
        AlmostEmpty = (sz <= 1);
        Count       = 3'(sz);
        DataOut     = pend_v ? pend_d : 8'h00;
    endtask

    task automatic commit();
        exp_t       e;
        exp_t       got;
        logic [7:0] err;
        int         sz;
        logic       pop_ok;
        logic       push_ok;
        sz  = mq.size();
        err = '0;
        if (Reset) begin
            mq.delete();
            pend_v = 1'b0;
            m_vec  = '0;
            m_cnt  = '0;
            m_fv   = 1'b0;
            m_fc   = '0;
        end else begin
            err[0] = Full != (sz == 4);
            err[1] = Empty != (sz == 0);
            err[2] = Push && (sz == 4);
            err[3] = Pop && (sz == 0);
            err[4] = pend_v && (DataOut != pend_d);
            err[5] = Count != 3'(sz);
            err[6] = AlmostFull != (sz >= 3);
            err[7] = AlmostEmpty != (sz <= 1);
            pop_ok  = Pop && (sz > 0);
            push_ok = Push && (sz < 4);
            pend_v  = pop_ok;
            if (pop_ok) begin
                pend_d = mq.pop_front();
            end
            if (push_ok) begin
                mq.push_back(DataIn);
            end
            if (ErrClear) begin
                m_vec = '0;
                m_cnt = '0;
                m_fv  = 1'b0;
                m_fc  = '0;
            end else begin
                m_vec = m_vec | err;
                if (err != 0) begin
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                    if (!m_fv) begin
                        m_fv = 1'b1;
                        for (int i = 7; i >= 0; i--) begin
                            if (err[i]) m_fc = 3'(i);
                        end
                    end
                end
            end
        end
        e.vec = m_vec;
        e.cnt = m_cnt;
        e.fv  = m_fv;
        e.fc  = m_fc;
        e.mc  = 3'(mq.size());
        sbq.push_back(e);
        @(posedge Clk);
        #1;
        got = sbq.pop_front();
        check("ErrVector", ErrVector, got.vec);
        check("ErrCount", ErrCount, got.cnt);
        check("FirstErrValid", FirstErrValid, got.fv);
        if (got.fv) check("FirstErrCode", FirstErrCode, got.fc);
        check("ModelCount", ModelCount, got.mc);
    endtask

    task automatic idle();
        setup(1'b0, 1'b0, 8'h00);
        commit();
    endtask

    task automatic push_w(input logic [7:0] d);
        setup(1'b1, 1'b0, d);
        commit();
    endtask

    task automatic pop_w();
        setup(1'b0, 1'b1, 8'h00);
        commit();
    endtask

    task automatic clear_w();
        setup(1'b0, 1'b0, 8'h00);
        ErrClear = 1'b1;
        commit();
    endtask

    initial begin
        setup(1'b0, 1'b0, 8'h00);
        Reset = 1'b1;
        commit();
        setup(1'b0, 1'b0, 8'h00);
        Reset = 1'b1;
        commit();
        check("rst_vec", ErrVector, 8'h00);
        check("rst_mc", ModelCount, 3'd0);

        for (int unsigned i = 1; i <= 4; i++) push_w(8'(i * 8'h11));
        check("fill_mc", ModelCount, 3'd4);
        check("fill_vec", ErrVector, 8'h00);

        push_w(8'h99);
        check("ovf_vec", ErrVector, 8'h04);
        check("ovf_cnt", ErrCount, 16'd1);
        check("ovf_code", FirstErrCode, 3'd2);
        check("ovf_mc", ModelCount, 3'd4);
        clear_w();

        pop_w();
        pop_w();
        pop_w();
        setup(1'b0, 1'b1, 8'h00);
        DataOut = 8'h55;
        commit();
        idle();
        check("data_vec", ErrVector, 8'h10);
        check("data_cnt", ErrCount, 16'd1);
        check("data_code", FirstErrCode, 3'd4);
        check("data_mc", ModelCount, 3'd0);
        clear_w();

        push_w(8'hA0);
        for (int unsigned i = 1; i <= 6; i++) begin
            setup(1'b1, 1'b1, 8'(8'hA0 + i));
            commit();
        end
        idle();
        check("wrap_vec", ErrVector, 8'h00);
        check("wrap_mc", ModelCount, 3'd1);

        push_w(8'hB0);
        for (int unsigned i = 0; i < 3; i++) begin
            setup(1'b0, 1'b0, 8'h00);
            Empty = 1'b1;
            commit();
        end
        check("empty_vec", ErrVector, 8'h02);
        check("empty_cnt", ErrCount, 16'd3);
        check("empty_code", FirstErrCode, 3'd1);
        setup(1'b0, 1'b0, 8'h00);
        Empty    = 1'b1;
        ErrClear = 1'b1;
        commit();
        check("clr_vec", ErrVector, 8'h00);
        check("clr_cnt", ErrCount, 16'd0);
        check("clr_fv", FirstErrValid, 1'b0);
        check("clr_mc", ModelCount, 3'd2);

        push_w(8'hC0);
        setup(1'b1, 1'b1, 8'hC1);
        commit();
        setup(1'b1, 1'b0, 8'hC2);
        Reset   = 1'b1;
        DataOut = 8'hEE;
        commit();
        setup(1'b0, 1'b0, 8'h00);
        DataOut = 8'hEE;
        commit();
        check("midrst_vec", ErrVector, 8'h00);
        check("midrst_cnt", ErrCount, 16'd0);
        check("midrst_mc", ModelCount, 3'd0);

        pop_w();
        check("unf_vec", ErrVector, 8'h08);
        check("unf_code", FirstErrCode, 3'd3);
        setup(1'b0, 1'b0, 8'h00);
        Count = 3'd2;
        commit();
        check("cnt_vec", ErrVector, 8'h28);
        check("cnt_cnt", ErrCount, 16'd2);
        check("cnt_code", FirstErrCode, 3'd3);
        clear_w();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
